// File: rtl/square_pkg.sv
// Shared definitions for the square drawing blocks (drawer, eraser, game control).
package square_pkg;

    localparam logic [11:0] SCREEN_W = 12'd640;
    localparam logic [11:0] SCREEN_H = 12'd480;

    // Raster counter width: enough for a column/row index of a 64-pixel square.
    localparam int CNT_W = 7;

    typedef logic [10:0] coord_t;
    typedef logic [CNT_W-1:0] scan_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    // Visibility test on 12-bit sums so that coordinates past 2047 never alias onto the screen.
    function automatic logic on_screen(input logic [11:0] x, input logic [11:0] y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/square_drawer_if.sv
// Request handshake plus pixel write port between a square drawer and its neighbours.
interface square_drawer_if #(
    parameter int COLOR_W = 24
);
    import square_pkg::*;

    logic               start;
    coord_t             x_loc;
    coord_t             y_loc;
    logic [COLOR_W-1:0] color;
    logic               pixel_ready;
    coord_t             pixel_x;
    coord_t             pixel_y;
    logic [COLOR_W-1:0] pixel_color;
    logic               pixel_write;
    logic               busy;
    logic               done;

    modport slave (
        input  start, x_loc, y_loc, color, pixel_ready,
        output pixel_x, pixel_y, pixel_color, pixel_write, busy, done
    );

    modport master (
        output start, x_loc, y_loc, color, pixel_ready,
        input  pixel_x, pixel_y, pixel_color, pixel_write, busy, done
    );

endinterface

// File: rtl/square_scan_counter.sv
// Row-major col/row raster counter over a SIZE x SIZE square, exposing the post-advance values.
module square_scan_counter
    import square_pkg::*;
#(
    parameter int SIZE = 40
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  en,
    output scan_t col_next,
    output scan_t row_next,
    output logic  last
);

    localparam scan_t LAST_IDX = scan_t'(SIZE - 1);

    scan_t col_reg;
    scan_t row_reg;
    logic  col_wrap;

    assign col_wrap = (col_reg == LAST_IDX);
    assign last     = col_wrap && (row_reg == LAST_IDX);
    assign col_next = col_wrap ? '0 : col_reg + scan_t'(1);
    assign row_next = col_wrap ? row_reg + scan_t'(1) : row_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clr) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (en) begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

endmodule

// File: rtl/square_drawer.sv
// Rasterises one clipped, filled square per start/done handshake onto a ready/valid pixel port.
module square_drawer
    import square_pkg::*;
#(
    parameter int SIZE    = 40,
    parameter int COLOR_W = 24
) (
    input  logic            clk,
    input  logic            reset,
    square_drawer_if.slave  bus
);

    draw_state_t        state_reg, state_next;
    coord_t             x0_reg, y0_reg;
    logic [COLOR_W-1:0] color_reg;
    coord_t             pixel_x_reg, pixel_x_next;
    coord_t             pixel_y_reg, pixel_y_next;
    logic               pixel_write_reg, pixel_write_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic        load;
    logic        cnt_clr;
    logic        cnt_en;
    logic        advance;
    scan_t       col_next;
    scan_t       row_next;
    logic        last;
    logic [11:0] sum_x;
    logic [11:0] sum_y;

    square_scan_counter #(
        .SIZE (SIZE)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .col_next (col_next),
        .row_next (row_next),
        .last     (last)
    );

    // Coordinate of the position that will be current after this edge.
    assign sum_x = {1'b0, x0_reg} + 12'(col_next);
    assign sum_y = {1'b0, y0_reg} + 12'(row_next);

    // A clipped pixel never waits for the frame buffer.
    assign advance = !pixel_write_reg || bus.pixel_ready;

    always_comb begin
        state_next       = state_reg;
        load             = 1'b0;
        cnt_clr          = 1'b0;
        cnt_en           = 1'b0;
        pixel_x_next     = pixel_x_reg;
        pixel_y_next     = pixel_y_reg;
        pixel_write_next = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    load             = 1'b1;
                    cnt_clr          = 1'b1;
                    state_next       = DRAW;
                    busy_next        = 1'b1;
                    pixel_x_next     = bus.x_loc;
                    pixel_y_next     = bus.y_loc;
                    pixel_write_next = on_screen({1'b0, bus.x_loc}, {1'b0, bus.y_loc});
                end
            end

            DRAW: begin
                busy_next        = 1'b1;
                pixel_write_next = pixel_write_reg;
                if (advance) begin
                    cnt_en = 1'b1;
                    if (last) begin
                        state_next       = DONE;
                        busy_next        = 1'b0;
                        done_next        = 1'b1;
                        pixel_write_next = 1'b0;
                    end else begin
                        pixel_x_next     = sum_x[10:0];
                        pixel_y_next     = sum_y[10:0];
                        pixel_write_next = on_screen(sum_x, sum_y);
                    end
                end
            end

            DONE: begin
                done_next = 1'b1;
                if (!bus.start) begin
                    state_next = IDLE;
                    done_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            x0_reg          <= '0;
            y0_reg          <= '0;
            color_reg       <= '0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            pixel_write_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pixel_x_reg     <= pixel_x_next;
            pixel_y_reg     <= pixel_y_next;
            pixel_write_reg <= pixel_write_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            if (load) begin
                x0_reg    <= bus.x_loc;
                y0_reg    <= bus.y_loc;
                color_reg <= bus.color;
            end
        end
    end

    assign bus.pixel_x     = pixel_x_reg;
    assign bus.pixel_y     = pixel_y_reg;
    assign bus.pixel_color = color_reg;
    assign bus.pixel_write = pixel_write_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;

endmodule

// File: tb/tb_square_drawer.sv
// Randomised bench for square_drawer against a position-list reference model.
module tb_square_drawer;

    localparam int S       = 4;
    localparam int COLOR_W = 24;
    localparam int LIMIT   = 200;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    square_drawer_if #(.COLOR_W(COLOR_W)) bus ();

    square_drawer #(
        .SIZE    (S),
        .COLOR_W (COLOR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low 3 cycles on the second pixel.
    task automatic run_square(input int x0, input int y0, input int mode, input bit disturb);
        logic [COLOR_W-1:0] col;
        int k, cycles, stall_left, exp_writes, dut_writes, hold;
        int ex, ey;
        bit vis, rdy;

        col = COLOR_W'($urandom);
        exp_writes = 0;
        for (int i = 0; i < S * S; i++) begin
            if ((x0 + i % S) < 640 && (y0 + i / S) < 480) exp_writes++;
        end

        bus.start       = 1'b1;
        bus.x_loc       = 11'(x0);
        bus.y_loc       = 11'(y0);
        bus.color       = col;
        bus.pixel_ready = 1'b1;
        step();

        k = 0;
        cycles = 0;
        dut_writes = 0;
        stall_left = (mode == 2) ? 3 : 0;
        while (k < S * S && cycles < LIMIT) begin
            ex  = x0 + k % S;
            ey  = y0 + k / S;
            vis = (ex < 640) && (ey < 480);
            check("busy", 32'(bus.busy), 32'd1);
            check("done_low", 32'(bus.done), 32'd0);
            check("write", 32'(bus.pixel_write), 32'(vis));
            check("px", 32'(bus.pixel_x), 32'(ex & 'h7ff));
            check("py", 32'(bus.pixel_y), 32'(ey & 'h7ff));
            check("color", 32'(bus.pixel_color), 32'(col));

            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && k == 1 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else rdy = 1'b1;
            bus.pixel_ready = rdy;
            if (disturb) begin
                bus.x_loc = 11'($urandom);
                bus.y_loc = 11'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end

            if (bus.pixel_write && rdy) dut_writes++;
            if (!vis || rdy) k++;
            cycles++;
            step();
        end
        if (cycles >= LIMIT) check("draw_timeout", 32'(cycles), 32'(LIMIT - 1));

        bus.start = 1'b1;
        bus.pixel_ready = 1'b1;
        check("writes", 32'(dut_writes), 32'(exp_writes));
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_done", 32'(bus.done), 32'd1);
        check("end_write", 32'(bus.pixel_write), 32'd0);

        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            step();
            check("done_hold", 32'(bus.done), 32'd1);
        end
        bus.start = 1'b0;
        step();
        check("done_fall", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        $display("square x0=%0d y0=%0d mode=%0d disturb=%0d cycles=%0d writes=%0d",
                 x0, y0, mode, disturb, cycles, dut_writes);
    endtask

    initial begin
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.x_loc       = '0;
        bus.y_loc       = '0;
        bus.color       = '0;
        bus.pixel_ready = 1'b1;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_write", 32'(bus.pixel_write), 32'd0);
        check("rst_px", 32'(bus.pixel_x), 32'd0);
        reset = 1'b1;
        step();

        run_square(10, 20, 0, 1'b0);
        run_square(638, 478, 0, 1'b0);
        run_square(10, 20, 2, 1'b0);
        run_square(10, 20, 1, 1'b1);

        // Asynchronous reset between edges while drawing.
        bus.start = 1'b1;
        bus.x_loc = 11'd100;
        bus.y_loc = 11'd100;
        bus.color = 24'hABCDEF;
        step();
        repeat (5) step();
        #2;
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_write", 32'(bus.pixel_write), 32'd0);
        check("arst_px", 32'(bus.pixel_x), 32'd0);
        check("arst_py", 32'(bus.pixel_y), 32'd0);
        check("arst_color", 32'(bus.pixel_color), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        #3;
        reset = 1'b1;
        step();
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        run_square(0, 0, 0, 1'b0);
        run_square(700, 0, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            int rx, ry;
            rx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(630, 660)) : int'($urandom_range(0, 2047));
            ry = ($urandom_range(0, 1) != 0) ? int'($urandom_range(470, 500)) : int'($urandom_range(0, 2047));
            run_square(rx, ry, 1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/square_drawer.md
# square_drawer

Rasterises one filled square per request into the VGA frame-buffer write port. Sits directly downstream of the square location picker: latches its `x_loc`/`y_loc`, then emits one pixel write per cycle, row-major, clipping against the 640x480 screen. Uses a four-phase start/done handshake that pairs with the picker's level-style `done`, plus a ready/valid stall on the pixel port.

## Interface
- `SIZE`, 40: square side length in pixels (1..64).
- `COLOR_W`, 24: pixel colour width (8-bit R, G, B).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: draw request; level, held until `done` seen.
- `x_loc` in 11: top-left column, sampled on accept.
- `y_loc` in 11: top-left row, sampled on accept.
- `color` in COLOR_W: fill colour, sampled on accept.
- `pixel_ready` in 1: frame buffer accepts the write this cycle.
- `pixel_x` out 11: current pixel column.
- `pixel_y` out 11: current pixel row.
- `pixel_color` out COLOR_W: latched colour.
- `pixel_write` out 1: pixel valid (write strobe).
- `busy` out 1: high in DRAW.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, DRAW, DONE.
- **IDLE**
  - `start`=1 latches `x_loc`, `y_loc` and `color`.
  - Clears `col` and `row` to 0 and moves to DRAW.
  - `start`=0: stay in IDLE.
- **DRAW**
  - `pixel_x` = x0+`col` and `pixel_y` = y0+`row`. Sums are computed 12 bits wide, so they never wrap.
  - Visible pixel (x<640 and y<480): `pixel_write`=1.
    - Counters advance only on a cycle with `pixel_ready`=1.
    - With `pixel_ready`=0, hold the outputs stable.
  - Clipped pixel: `pixel_write`=0 and the counters advance unconditionally, without waiting for ready.
  - Counter advance: `col` increments. At `col`=SIZE-1 it wraps to 0 and `row` increments.
  - Advancing from (`col`,`row`)=(SIZE-1,SIZE-1) moves to DONE.
- **DONE**
  - `done` stays 1 while `start`=1.
  - `start`=0 returns to IDLE with `done`=0 on the next cycle.
- Changes to `start`, `x_loc` and `y_loc` during DRAW are ignored.
- Reset (async, any state):
  - State goes to IDLE.
  - `pixel_x`, `pixel_y`, `pixel_color`, `pixel_write`, `busy`, `done` = 0; counters = 0.
- Fully off-screen square (e.g. x0=700): still walks all SIZE*SIZE positions with `pixel_write`=0, then reaches DONE.

## Timing
- Accept edge: `start`=1 is sampled in IDLE; `busy`=1 and the first pixel is presented on the next cycle.
- Draw length: with `pixel_ready` held at 1, DRAW lasts exactly SIZE*SIZE cycles.
- Stalls: each `pixel_ready`=0 cycle on a visible pixel adds one cycle.
- `done` rises on the cycle after the final pixel advance.
- Return to IDLE: `done` falls one cycle after `start` falls. A new accept is possible on the following edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Total handshake latency, with no stalls and `start` dropped immediately: 1 + SIZE*SIZE + 2 cycles.

## Structure
- Shared package `square_pkg` holds:
  - `SCREEN_W`=640 and `SCREEN_H`=480;
  - `typedef logic [10:0] coord_t`;
  - the draw state enum (IDLE, DRAW, DONE), reused by the eraser and game control.
- One natural sub-module: `square_scan_counter`.
  - Does the col/row raster count with an enable input, a clear input and a `last` flag.
  - The FSM, clipping and output registers stay in `square_drawer`.

## Test plan
- SIZE=4, x0=10, y0=20, `pixel_ready`=1, `start` held:
  - 16 writes in order (10,20),(11,20)..(13,23);
  - `done`=1 on cycle 18 after accept;
  - `start`↓ → `done`=0 one cycle later.
- SIZE=4, x0=638, y0=478:
  - writes only (638,478),(639,478),(638,479),(639,479);
  - DRAW still lasts 16 cycles.
- `pixel_ready`=0 for 3 cycles at pixel (11,20):
  - outputs hold (11,20) with `pixel_write`=1;
  - total DRAW = 19 cycles; no duplicate or skipped coordinates.
- `x_loc`/`y_loc` toggled and `start` pulsed low/high during DRAW: coordinates are unaffected and no restart occurs.
- `reset`=0 asserted mid-DRAW (asynchronous, between edges):
  - all outputs 0 immediately;
  - after release, `start` with x0=0, y0=0 begins at (0,0).
- x0=700, y0=0: zero writes, `done` after 16 cycles (SIZE=4).
